// File: rtl/mont_enc_pkg.sv
// Shared definitions for the Montgomery-domain encoder: default data width,
// a constant clog2 helper and the FSM state encoding.
package mont_enc_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int clog2(input int unsigned n);
    int r;
    r = 0;
    for (int unsigned v = 1; v < n; v = v << 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mont_enc_if.sv
// Operand/result handshake bundle for mont_enc; master is the producer/consumer
// side, slave is the encoder.
interface mont_enc_if #(
  parameter int DATA_W = mont_enc_pkg::DATA_W_DEF
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_q;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_c;
  logic              out_err;

  modport master (
    output in_valid, in_a, in_q, out_ready,
    input  in_ready, out_valid, out_c, out_err
  );

  modport slave (
    input  in_valid, in_a, in_q, out_ready,
    output in_ready, out_valid, out_c, out_err
  );
endinterface

// File: rtl/mont_enc_mod_dbl.sv
// Combinational modular doubling: y = (2x >= q) ? 2x - q : 2x.
module mod_dbl #(
  parameter int DATA_W = mont_enc_pkg::DATA_W_DEF
) (
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] y
);
  logic [DATA_W:0] t;

  // Compare on the full DATA_W+1-bit product; the low-bit subtraction is exact
  // whenever x < q because the true difference then fits in DATA_W bits.
  always_comb begin
    t = {x, 1'b0};
    if (t >= {1'b0, q}) begin
      y = t[DATA_W-1:0] - q;
    end else begin
      y = t[DATA_W-1:0];
    end
  end
endmodule

// File: rtl/mont_enc.sv
// Montgomery-domain encoder: computes a*2^SHIFT mod q by SHIFT modular
// doublings, one per clock, with valid/ready handshakes on both sides.
module mont_enc
  import mont_enc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SHIFT  = 32
) (
  input logic       clk,
  input logic       reset,
  mont_enc_if.slave bus
);
  localparam int CNT_W = (clog2(SHIFT + 1) < 1) ? 1 : clog2(SHIFT + 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] q_q;
  logic [DATA_W-1:0] dbl;
  logic [CNT_W-1:0]  cnt_q;
  logic              err_q;
  logic              accept;

  mod_dbl #(.DATA_W(DATA_W)) u_dbl (
    .x(acc_q),
    .q(q_q),
    .y(dbl)
  );

  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_c     = '0;
    bus.out_err   = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = (SHIFT > 0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
        bus.out_c     = acc_q;
        bus.out_err   = err_q;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      q_q   <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      acc_q <= bus.in_a;
      q_q   <= bus.in_q;
      cnt_q <= CNT_W'(SHIFT);
      err_q <= (bus.in_a >= bus.in_q);
    end else if (state_q == RUN) begin
      acc_q <= dbl;
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_mont_enc.sv
// Self-checking bench for mont_enc: directed vectors, backpressure, reset abort,
// SHIFT=0 passthrough and random operations against a*2^SHIFT mod q.
module tb_mont_enc;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mont_enc_if #(.DATA_W(16)) if16 ();
  mont_enc_if #(.DATA_W(16)) if0 ();

  mont_enc #(.DATA_W(16), .SHIFT(16)) dut16 (.clk(clk), .reset(reset), .bus(if16.slave));
  mont_enc #(.DATA_W(16), .SHIFT(0))  dut0  (.clk(clk), .reset(reset), .bus(if0.slave));

  int          sel = 0;
  logic        tv = 1'b0;
  logic        tr = 1'b0;
  logic [15:0] ta = '0;
  logic [15:0] tq = 16'd7681;

  assign if16.in_valid  = tv && (sel == 0);
  assign if16.in_a      = ta;
  assign if16.in_q      = tq;
  assign if16.out_ready = tr && (sel == 0);
  assign if0.in_valid   = tv && (sel == 1);
  assign if0.in_a       = ta;
  assign if0.in_q       = tq;
  assign if0.out_ready  = tr && (sel == 1);

  logic        m_in_ready, m_out_valid, m_out_err;
  logic [15:0] m_out_c;
  assign m_in_ready  = (sel == 1) ? if0.in_ready  : if16.in_ready;
  assign m_out_valid = (sel == 1) ? if0.out_valid : if16.out_valid;
  assign m_out_c     = (sel == 1) ? if0.out_c     : if16.out_c;
  assign m_out_err   = (sel == 1) ? if0.out_err   : if16.out_err;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_mont(input logic [15:0] a, input logic [15:0] q, input int sh);
    longint unsigned v;
    v = 64'(a);
    v = (v << sh) % 64'(q);
    return v[15:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation: accept, measure latency, optional backpressure, release.
  task automatic run_op(input logic [15:0] a, input logic [15:0] q, input int hold,
                        output logic [15:0] c, output logic e, output int lat);
    int wait_cnt;
    logic [15:0] c0;
    logic e0;
    c = '0; e = 1'b0; lat = -1;
    wait_cnt = 0;
    while (!m_in_ready && wait_cnt < 100) begin
      tick();
      wait_cnt++;
    end
    if (!m_in_ready) begin
      check("in_ready_timeout", 64'(m_in_ready), 64'd1);
      return;
    end
    tv = 1'b1; ta = a; tq = q;
    tick();
    tv = 1'b0;
    ta = ~a; tq = ~q;
    lat = 0;
    if (sel == 0) check("in_ready_busy", 64'(m_in_ready), 64'd0);
    while (!m_out_valid && lat < 100) begin
      tick();
      lat++;
    end
    if (!m_out_valid) begin
      check("out_valid_timeout", 64'(m_out_valid), 64'd1);
      return;
    end
    c0 = m_out_c; e0 = m_out_err;
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", 64'(m_out_valid), 64'd1);
      check("hold_c", 64'(m_out_c), 64'(c0));
      check("hold_err", 64'(m_out_err), 64'(e0));
      check("hold_in_ready", 64'(m_in_ready), 64'd0);
    end
    c = c0; e = e0;
    tr = 1'b1;
    tick();
    tr = 1'b0;
    check("release_in_ready", 64'(m_in_ready), 64'd1);
    check("release_out_valid", 64'(m_out_valid), 64'd0);
  endtask

  initial begin
    logic [15:0] c, a, q;
    logic e;
    int lat;

    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_in_ready", 64'(if16.in_ready), 64'd1);
    check("rst_out_valid", 64'(if16.out_valid), 64'd0);
    check("rst_out_c", 64'(if16.out_c), 64'd0);
    check("rst_out_err", 64'(if16.out_err), 64'd0);

    run_op(16'd1, 16'd7681, 0, c, e, lat);
    check("a1_c", 64'(c), 64'd4088);
    check("a1_err", 64'(e), 64'd0);
    check("a1_lat", 64'(lat), 64'd16);

    run_op(16'd0, 16'd7681, 0, c, e, lat);
    check("a0_c", 64'(c), 64'd0);
    run_op(16'd7680, 16'd7681, 0, c, e, lat);
    check("amax_c", 64'(c), 64'd3593);
    run_op(16'd1, 16'd12289, 0, c, e, lat);
    check("q12289_c", 64'(c), 64'd4091);

    run_op(16'd7681, 16'd7681, 0, c, e, lat);
    check("err_flag", 64'(e), 64'd1);
    check("err_lat", 64'(lat), 64'd16);
    run_op(16'd5, 16'd7681, 0, c, e, lat);
    check("post_err_flag", 64'(e), 64'd0);
    check("post_err_c", 64'(c), 64'(ref_mont(16'd5, 16'd7681, 16)));

    run_op(16'd77, 16'd7681, 5, c, e, lat);
    check("bp_c", 64'(c), 64'(ref_mont(16'd77, 16'd7681, 16)));

    // Abort an operation five cycles into RUN.
    tv = 1'b1; ta = 16'd3000; tq = 16'd7681;
    tick();
    tv = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    check("abort_out_valid", 64'(if16.out_valid), 64'd0);
    check("abort_in_ready", 64'(if16.in_ready), 64'd1);
    reset = 1'b0;
    run_op(16'd1, 16'd7681, 0, c, e, lat);
    check("post_abort_c", 64'(c), 64'd4088);
    check("post_abort_lat", 64'(lat), 64'd16);

    for (int i = 0; i < 20; i++) begin
      q = 16'($urandom_range(1, 32767) * 2 + 1);
      a = 16'($urandom % 32'(q));
      run_op(a, q, int'($urandom_range(0, 2)), c, e, lat);
      check("rnd16_c", 64'(c), 64'(ref_mont(a, q, 16)));
      check("rnd16_err", 64'(e), 64'd0);
      check("rnd16_lat", 64'(lat), 64'd16);
    end

    sel = 1;
    tick();
    run_op(16'd1234, 16'd7681, 0, c, e, lat);
    check("sh0_c", 64'(c), 64'd1234);
    check("sh0_lat", 64'(lat), 64'd0);
    for (int i = 0; i < 8; i++) begin
      q = 16'($urandom_range(1, 32767) * 2 + 1);
      a = 16'($urandom % 32'(q));
      run_op(a, q, 0, c, e, lat);
      check("rnd0_c", 64'(c), 64'(ref_mont(a, q, 0)));
      check("rnd0_err", 64'(e), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
